pingpong_drain: RTL and testbench

PINGPONG_DRAIN -- requirements
Module: pingpong_drain

---
 rtl/pingpong_drain.sv | 178 +++++++++++++++++
 tb/tb_pingpong_drain.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pingpong_drain.sv
// Ping-pong FIFO drain: tracks frames written into two FIFO banks (A = 1/2,
// B = 3/4), then reads complete frames out strictly alternating between banks
// and marks each frame with start, end and bank flags.
module pingpong_drain (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        enable,
  input  logic [12:0] packer_len,
  input  logic        fifo_wr1,
  input  logic        fifo_wr2,
  input  logic        fifo_wr3,
  input  logic        fifo_wr4,
  input  logic        out_ready,
  output logic        fifo_rd1,
  output logic        fifo_rd2,
  output logic        fifo_rd3,
  output logic        fifo_rd4,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_bank,
  output logic        fifo_flush,
  output logic        ovf_err,
  output logic        pair_err
);

  localparam int unsigned LEN_W  = 13;
  localparam int unsigned PEND_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   last_idx;
  logic [LEN_W-1:0]   wc_a_q, wc_b_q, rc_q;
  logic [PEND_W-1:0]  pend_a_q, pend_b_q;
  logic               next_bank_q;

  logic               comp_a, comp_b;
  logic               rd_a_c, rd_b_c, rd_c, last_rd_c;
  logic               done_a, done_b;
  logic               abort_c;
  logic               ovf_a, ovf_b;

  // Simulink clock-enable port is accepted but has no effect
  logic               ce_unused;
  assign ce_unused = ce;

  // Frame length 0 wraps to 8191, i.e. an 8192-word frame
  assign last_idx = len_q - LEN_W'(1);

  assign comp_a = enable && fifo_wr1 && (wc_a_q == last_idx);
  assign comp_b = enable && fifo_wr3 && (wc_b_q == last_idx);
  assign done_a = rd_a_c && last_rd_c;
  assign done_b = rd_b_c && last_rd_c;
  assign ovf_a  = comp_a && !done_a && (pend_a_q == PEND_W'(3));
  assign ovf_b  = comp_b && !done_b && (pend_b_q == PEND_W'(3));

  assign abort_c = !enable && ((state_q != IDLE) || (|wc_a_q) || (|wc_b_q) ||
                               (|rc_q) || (|pend_a_q) || (|pend_b_q));

  assign fifo_rd1 = rd_a_c;
  assign fifo_rd2 = rd_a_c;
  assign fifo_rd3 = rd_b_c;
  assign fifo_rd4 = rd_b_c;

  // Pending-frame count: saturates at 3, simultaneous inc/dec cancels
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p,
                                                   input logic inc, input logic dec);
    logic [PEND_W-1:0] r;
    r = p;
    if (inc && !dec && (p != PEND_W'(3))) r = p + PEND_W'(1);
    else if (dec && !inc)                 r = p - PEND_W'(1);
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: serve the bank whose turn it is, return to IDLE after each frame
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!next_bank_q && (pend_a_q != '0))     state_d = RD_A;
          else if (next_bank_q && (pend_b_q != '0)) state_d = RD_B;
        end
        RD_A, RD_B: if (last_rd_c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read strobes: issued while reading a bank and the sink will take a word
  always_comb begin
    rd_a_c    = 1'b0;
    rd_b_c    = 1'b0;
    case (state_q)
      RD_A:    rd_a_c = enable && out_ready;
      RD_B:    rd_b_c = enable && out_ready;
      default: ;
    endcase
    rd_c      = rd_a_c || rd_b_c;
    last_rd_c = rd_c && (rc_q == last_idx);
  end

  // Frame length capture while acquisition is stopped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        len_q <= '0;
    else if (!enable) len_q <= packer_len;
  end

  // Write/read progress, pending frames and bank turn; all cleared while stopped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc_a_q      <= '0;
      wc_b_q      <= '0;
      rc_q        <= '0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      next_bank_q <= 1'b0;
    end else if (!enable) begin
      wc_a_q      <= '0;
      wc_b_q      <= '0;
      rc_q        <= '0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      next_bank_q <= 1'b0;
    end else begin
      if (fifo_wr1) wc_a_q <= comp_a ? '0 : wc_a_q + LEN_W'(1);
      if (fifo_wr3) wc_b_q <= comp_b ? '0 : wc_b_q + LEN_W'(1);
      if (rd_c)     rc_q   <= last_rd_c ? '0 : rc_q + LEN_W'(1);
      pend_a_q <= pend_next(pend_a_q, comp_a, done_a);
      pend_b_q <= pend_next(pend_b_q, comp_b, done_b);
      if (last_rd_c) next_bank_q <= ~next_bank_q;
    end
  end

  // Output word flags follow the read strobe by the FIFO read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_bank  <= 1'b0;
    end else begin
      out_valid <= rd_c;
      out_sop   <= rd_c && (rc_q == '0);
      out_eop   <= last_rd_c;
      if (rd_c) out_bank <= rd_b_c;
    end
  end

  // Flush pulse on abort and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_flush <= 1'b0;
      ovf_err    <= 1'b0;
      pair_err   <= 1'b0;
    end else begin
      fifo_flush <= abort_c;
      if (ovf_a || ovf_b) ovf_err <= 1'b1;
      if ((fifo_wr1 != fifo_wr2) || (fifo_wr3 != fifo_wr4)) pair_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_drain.sv
// Directed bench for pingpong_drain: frame drain order, ready throttling,
// saturation, abort/flush, pairing error and asynchronous reset.
module tb_pingpong_drain;

  logic        clk = 1'b0;
  logic        reset, ce, enable;
  logic [12:0] packer_len;
  logic        fifo_wr1, fifo_wr2, fifo_wr3, fifo_wr4, out_ready;
  logic        fifo_rd1, fifo_rd2, fifo_rd3, fifo_rd4;
  logic        out_valid, out_sop, out_eop, out_bank;
  logic        fifo_flush, ovf_err, pair_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc_n, sa_n, sb_n, wq_n, odd_n;
  logic [63:0] sa_pk, sb_pk, wq_pk;
  logic        s_rda, s_val, s_flush, s_ovf, s_pair;

  always #5 clk = ~clk;

  pingpong_drain dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .enable     (enable),
    .packer_len (packer_len),
    .fifo_wr1   (fifo_wr1),
    .fifo_wr2   (fifo_wr2),
    .fifo_wr3   (fifo_wr3),
    .fifo_wr4   (fifo_wr4),
    .out_ready  (out_ready),
    .fifo_rd1   (fifo_rd1),
    .fifo_rd2   (fifo_rd2),
    .fifo_rd3   (fifo_rd3),
    .fifo_rd4   (fifo_rd4),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_bank   (out_bank),
    .fifo_flush (fifo_flush),
    .ovf_err    (ovf_err),
    .pair_err   (pair_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc_n = 0; sa_n = 0; sb_n = 0; wq_n = 0; odd_n = 0;
    sa_pk = '0; sb_pk = '0; wq_pk = '0;
  endtask

  // One clock cycle: apply inputs, log strobes/words of this cycle, advance
  task automatic cyc4(input logic en, input logic w1, input logic w2,
                      input logic w3, input logic w4, input logic rdy);
    enable = en; fifo_wr1 = w1; fifo_wr2 = w2; fifo_wr3 = w3; fifo_wr4 = w4;
    out_ready = rdy;
    #1;
    if (fifo_rd1 && fifo_rd2) begin sa_pk = (sa_pk << 8) | 64'(8'(cyc_n)); sa_n++; end
    if (fifo_rd3 && fifo_rd4) begin sb_pk = (sb_pk << 8) | 64'(8'(cyc_n)); sb_n++; end
    if ((fifo_rd1 != fifo_rd2) || (fifo_rd3 != fifo_rd4) ||
        ((fifo_rd1 || fifo_rd3) && !rdy) || (fifo_rd1 && fifo_rd3)) odd_n++;
    if (out_valid) begin
      wq_pk = (wq_pk << 3) | 64'({out_bank, out_sop, out_eop});
      wq_n++;
    end
    s_rda = fifo_rd1; s_val = out_valid; s_flush = fifo_flush;
    s_ovf = ovf_err;  s_pair = pair_err;
    cyc_n++;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic en, input logic wa, input logic wb, input logic rdy);
    cyc4(en, wa, wa, wb, wb, rdy);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; enable = 1'b0; packer_len = 13'd4;
    fifo_wr1 = 1'b0; fifo_wr2 = 1'b0; fifo_wr3 = 1'b0; fifo_wr4 = 1'b0;
    out_ready = 1'b0;
    clr();
    #3;
    chk("reset_outputs", 64'({fifo_rd1, fifo_rd2, fifo_rd3, fifo_rd4, out_valid, out_sop,
                              out_eop, out_bank, fifo_flush, ovf_err, pair_err}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // L=4, A frame then B frame, ready always high
    clr();
    for (int k = 0; k < 18; k++) cyc(1, k < 4, (k >= 4) && (k < 8), 1);
    chk("t1_a_strobes", sa_pk, 64'h05060708);
    chk("t1_b_strobes", sb_pk, 64'h0A0B0C0D);
    chk("t1_words_n", 64'(wq_n), 64'd8);
    chk("t1_words", wq_pk, 64'(24'b010_000_000_001_110_100_100_101));
    chk("t1_odd", 64'(odd_n), 64'd0);

    // L=4, ready toggling 1,0,1,0
    clr();
    for (int k = 0; k < 24; k++) cyc(1, k < 4, (k >= 4) && (k < 8), (k % 2) == 0);
    chk("t2_a_strobes", sa_pk, 64'h06080A0C);
    chk("t2_b_strobes", sb_pk, 64'h0E101214);
    chk("t2_words", wq_pk, 64'(24'b010_000_000_001_110_100_100_101));
    chk("t2_odd", 64'(odd_n), 64'd0);

    // Re-latch L=2 through an idle enable drop (no flush expected)
    packer_len = 13'd2;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_idle_drop_flush", 64'(s_flush), 64'd0);

    // L=2, 8 frames written with ready low: saturation and overflow
    clr();
    for (int k = 0; k < 16; k++) begin
      cyc(1, ((k / 2) % 2) == 0, ((k / 2) % 2) == 1, 0);
      if (k == 12) chk("t3_ovf_before", 64'(s_ovf), 64'd0);
    end
    chk("t3_ovf_after", 64'(s_ovf), 64'd1);
    chk("t3_no_strobe_ready_low", 64'(sa_n + sb_n), 64'd0);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, 1);
    chk("t3_a_strobes", sa_pk, 64'h101116171C1D);
    chk("t3_b_strobes", sb_pk, 64'h1314191A1F20);
    chk("t3_words_n", 64'(wq_n), 64'd12);
    chk("t3_words", wq_pk, 64'(36'b010001110101_010001110101_010001110101));

    // L=2, A frame completes on the same cycle as the final A read
    clr();
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(1, 0, 1, 1); cyc(1, 0, 1, 1);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 1);
    chk("t4_a_strobes", sa_pk, 64'h03040B0C);
    chk("t4_b_strobes", sb_pk, 64'h0809);
    chk("t4_words", wq_pk, 64'(18'b010_001_110_101_010_001));
    chk("t4_odd", 64'(odd_n), 64'd0);

    // L=4, enable drops after two reads of an A frame
    packer_len = 13'd4;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    clr();
    for (int k = 0; k < 7; k++) cyc(1, k < 4, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t5_no_third_strobe", 64'(s_rda), 64'd0);
    chk("t5_inflight_valid", 64'(s_val), 64'd1);
    cyc(0, 0, 0, 1);
    chk("t5_flush_pulse", 64'(s_flush), 64'd1);
    chk("t5_valid_after", 64'(s_val), 64'd0);
    cyc(0, 0, 0, 1);
    chk("t5_flush_single", 64'(s_flush), 64'd0);
    chk("t5_strobes", sa_pk, 64'h0506);
    chk("t5_words", wq_pk, 64'(6'b010_000));
    chk("t5_ovf_sticky", 64'(s_ovf), 64'd1);

    // Restart: B frame written first must wait for bank A
    clr();
    for (int k = 0; k < 20; k++) cyc(1, (k >= 4) && (k < 8), k < 4, 1);
    chk("t5r_a_strobes", sa_pk, 64'h090A0B0C);
    chk("t5r_b_strobes", sb_pk, 64'h0E0F1011);
    chk("t5r_words", wq_pk, 64'(24'b010_000_000_001_110_100_100_101));

    // Pairing error, then asynchronous reset in the middle of a B frame
    cyc(0, 0, 0, 1);
    chk("t6_pair_before", 64'(s_pair), 64'd0);
    cyc4(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t6_pair_set", 64'(s_pair), 64'd1);
    clr();
    for (int k = 0; k < 11; k++) cyc(1, k < 4, (k >= 4) && (k < 8), 1);
    chk("t6_pair_held", 64'(pair_err), 64'd1);
    chk("t6_mid_b", 64'({fifo_rd3, out_valid, out_bank}), 64'b111);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_reset", 64'({fifo_rd1, fifo_rd2, fifo_rd3, fifo_rd4, out_valid, out_sop,
                               out_eop, out_bank, fifo_flush, ovf_err, pair_err}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clr();
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 1);
    chk("t6_discarded", 64'(sa_n + sb_n + wq_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
